// File: rtl/return_stack_if.sv
// Return-stack interface: bundles the decoder/PC-stage request signals and
// the stack status/readout signals seen by the next-PC mux.
//   master : drives enable, stack_enable, stack_write, push_addr, ctx_sel;
//            observes top_addr, depth_count, empty, full, overflow, underflow
//   slave  : the return stack itself (opposite directions)
interface return_stack_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16,
    parameter int CTX_W  = 1
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              enable;
    logic              stack_enable;
    logic              stack_write;
    logic [ADDR_W-1:0] push_addr;
    logic [CTX_W-1:0]  ctx_sel;
    logic [ADDR_W-1:0] top_addr;
    logic [CNT_W-1:0]  depth_count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output enable, stack_enable, stack_write, push_addr, ctx_sel,
        input  top_addr, depth_count, empty, full, overflow, underflow
    );

    modport slave (
        input  enable, stack_enable, stack_write, push_addr, ctx_sel,
        output top_addr, depth_count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack with one independent stack per execution
// context. JAL pushes the link address, RET pops and uses top_addr in the
// same cycle. Readout is combinational from the context chosen by ctx_sel.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (clears storage, pointers, flags)
//   bus  : return_stack_if.slave (request inputs, status/readout outputs)
module return_stack #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16,
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1
) (
    input  logic           clk,
    input  logic           rst,
    return_stack_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] entry_r [NUM_CTX][DEPTH];
    logic [PTR_W-1:0]  ptr_r   [NUM_CTX];
    logic              overflow_r;
    logic              underflow_r;

    logic              ctx_valid_s;
    logic [PTR_W-1:0]  sel_ptr_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [ADDR_W-1:0] top_addr_s;
    logic              empty_s;
    logic              full_s;
    logic              op_s;
    logic              push_ok_s;
    logic              push_ovf_s;
    logic              pop_ok_s;
    logic              pop_unf_s;

    // A ctx_sel code beyond NUM_CTX addresses no stack: it reads as empty
    // and requests made with it are ignored (flags included).
    generate
        if (NUM_CTX >= (1 << CTX_W)) begin : g_ctx_all
            assign ctx_valid_s = 1'b1;
        end else begin : g_ctx_chk
            assign ctx_valid_s = ({1'b0, bus.ctx_sel} < (CTX_W + 1)'(NUM_CTX));
        end
    endgenerate

    // Select the active context pointer and derive read/write indices.
    always_comb begin
        sel_ptr_s = PTR_ZERO;
        if (ctx_valid_s) begin
            sel_ptr_s = ptr_r[bus.ctx_sel];
        end else begin
            sel_ptr_s = PTR_ZERO;
        end
        // Pointer counts entries, so the top lives one below it; the write
        // slot is the pointer itself (only used when not full).
        top_idx_s = IDX_W'(sel_ptr_s - PTR_ONE);
        wr_idx_s  = IDX_W'(sel_ptr_s);
        empty_s   = (sel_ptr_s == PTR_ZERO);
        full_s    = (sel_ptr_s == PTR_FULL);
    end

    // Zero-latency top-of-stack readout; an empty stack reads as zero.
    always_comb begin
        top_addr_s = {ADDR_W{1'b0}};
        if (!empty_s) begin
            top_addr_s = entry_r[bus.ctx_sel][top_idx_s];
        end else begin
            top_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Decode the requested operation against the selected stack's state.
    always_comb begin
        op_s       = bus.enable & bus.stack_enable & ctx_valid_s;
        push_ok_s  = op_s &  bus.stack_write & ~full_s;
        push_ovf_s = op_s &  bus.stack_write &  full_s;
        pop_ok_s   = op_s & ~bus.stack_write & ~empty_s;
        pop_unf_s  = op_s & ~bus.stack_write &  empty_s;
    end

    // Stack storage, per-context pointers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                ptr_r[c] <= PTR_ZERO;
                for (int d = 0; d < DEPTH; d++) begin
                    entry_r[c][d] <= {ADDR_W{1'b0}};
                end
            end
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                entry_r[bus.ctx_sel][wr_idx_s] <= bus.push_addr;
                ptr_r[bus.ctx_sel]             <= sel_ptr_s + PTR_ONE;
            end
            // Popped entries stay in place; only the pointer moves.
            if (pop_ok_s) begin
                ptr_r[bus.ctx_sel] <= sel_ptr_s - PTR_ONE;
            end
            if (push_ovf_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_unf_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.top_addr    = top_addr_s;
    assign bus.depth_count = sel_ptr_s;
    assign bus.empty       = empty_s;
    assign bus.full        = full_s;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
endmodule

// File: tb/tb_return_stack.sv
// Directed testbench for return_stack with a queue-based reference model and
// a scoreboard of expected return/push values.
module tb_return_stack;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 16;
    localparam int NUM_CTX = 2;
    localparam int CTX_W   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    return_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CTX_W(CTX_W)) bus ();

    return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl0[$];
    logic [31:0] mdl1[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msize(input logic c);
        return c ? mdl1.size() : mdl0.size();
    endfunction

    function automatic logic [31:0] mtop(input logic c);
        if (c) return (mdl1.size() > 0) ? mdl1[$] : 32'h0;
        else   return (mdl0.size() > 0) ? mdl0[$] : 32'h0;
    endfunction

    task automatic mpush(input logic c, input logic [31:0] a);
        if (c) mdl1.push_back(a); else mdl0.push_back(a);
    endtask

    task automatic mpop(input logic c);
        if (c) void'(mdl1.pop_back()); else void'(mdl0.pop_back());
    endtask

    task automatic drive(input logic en, input logic se, input logic sw,
                         input logic [31:0] a, input logic c);
        bus.enable       = en;
        bus.stack_enable = se;
        bus.stack_write  = sw;
        bus.push_addr    = a;
        bus.ctx_sel      = c;
    endtask

    task automatic check_model(input string tag);
        logic c;
        c = bus.ctx_sel;
        chk({tag, ".depth"},     32'(bus.depth_count), 32'(msize(c)));
        chk({tag, ".empty"},     32'(bus.empty),       32'(msize(c) == 0));
        chk({tag, ".full"},      32'(bus.full),        32'(msize(c) == DEPTH));
        chk({tag, ".top"},       bus.top_addr,         mtop(c));
        chk({tag, ".overflow"},  32'(bus.overflow),    32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow),   32'(m_unf));
    endtask

    // One clock: update the model for the request on the bus, compare the
    // same-cycle return target for pops, then compare state after the edge.
    task automatic tick(input string tag);
        logic c;
        bit   push_pending;
        push_pending = 1'b0;
        #1;
        c = bus.ctx_sel;
        if (rst) begin
            mdl0.delete();
            mdl1.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.enable && bus.stack_enable) begin
            if (bus.stack_write) begin
                if (msize(c) == DEPTH) m_ovf = 1'b1;
                else begin
                    mpush(c, bus.push_addr);
                    sb.push_back(bus.push_addr);
                    push_pending = 1'b1;
                end
            end else begin
                if (msize(c) == 0) m_unf = 1'b1;
                else begin
                    sb.push_back(mtop(c));
                    mpop(c);
                    chk({tag, ".ret_target"}, bus.top_addr, sb.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (push_pending) chk({tag, ".pushed_top"}, bus.top_addr, sb.pop_front());
        check_model(tag);
    endtask

    task automatic peek(input string tag, input logic [31:0] top, input int depth);
        #1;
        chk({tag, ".top"},   bus.top_addr,         top);
        chk({tag, ".depth"}, 32'(bus.depth_count), 32'(depth));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();
        chk("rst.top", bus.top_addr, 32'h0);
        chk("rst.depth", 32'(bus.depth_count), 32'd0);
        chk("rst.empty", 32'(bus.empty), 32'd1);
        chk("rst.full", 32'(bus.full), 32'd0);

        // Push three, pop three
        drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b0); tick("push10");
        drive(1'b1, 1'b1, 1'b1, 32'h20, 1'b0); tick("push20");
        drive(1'b1, 1'b1, 1'b1, 32'h30, 1'b0); tick("push30");
        chk("three.depth", 32'(bus.depth_count), 32'd3);
        chk("three.top", bus.top_addr, 32'h30);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        #1; chk("pop1.top", bus.top_addr, 32'h30); tick("pop1");
        chk("pop2.top", bus.top_addr, 32'h20); tick("pop2");
        chk("pop3.top", bus.top_addr, 32'h10); tick("pop3");
        chk("popped.empty", 32'(bus.empty), 32'd1);
        chk("popped.top", bus.top_addr, 32'h0);
        chk("popped.underflow", 32'(bus.underflow), 32'd0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
            tick("fill");
            if (i == DEPTH - 2) chk("fill.not_full_yet", 32'(bus.full), 32'd0);
        end
        chk("fill.full", 32'(bus.full), 32'd1);
        chk("fill.overflow", 32'(bus.overflow), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0); tick("push_full");
        chk("ovf.flag", 32'(bus.overflow), 32'd1);
        chk("ovf.top", bus.top_addr, 32'h10F);
        chk("ovf.depth", 32'(bus.depth_count), 32'd16);
        do_reset();

        // Underflow from empty, then push
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick("pop_empty");
        chk("unf.flag", 32'(bus.underflow), 32'd1);
        chk("unf.depth", 32'(bus.depth_count), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h44, 1'b0); tick("push44");
        chk("unf.top44", bus.top_addr, 32'h44);
        chk("unf.sticky", 32'(bus.underflow), 32'd1);
        do_reset();

        // Context isolation
        drive(1'b1, 1'b1, 1'b1, 32'hA, 1'b0); tick("c0_pushA");
        drive(1'b1, 1'b1, 1'b1, 32'hB, 1'b1); tick("c1_pushB");
        drive(1'b1, 1'b1, 1'b1, 32'hC, 1'b1); tick("c1_pushC");
        peek("ctx1", 32'hC, 2);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        peek("ctx0_switch", 32'hA, 1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick("c0_pop");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        peek("ctx1_after", 32'hC, 2);
        do_reset();

        // Enable low freezes everything
        drive(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
        repeat (3) tick("frozen_push");
        chk("frozen.depth", 32'(bus.depth_count), 32'd0);
        chk("frozen.top", bus.top_addr, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick("frozen_pop");
        chk("frozen.underflow", 32'(bus.underflow), 32'd0);

        // Reset wins over a simultaneous push; flags clear too
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); tick("c1_pop_empty");
        drive(1'b1, 1'b1, 1'b1, 32'h1, 1'b0); tick("push1");
        drive(1'b1, 1'b1, 1'b1, 32'h2, 1'b0); tick("push2");
        drive(1'b1, 1'b1, 1'b1, 32'h77, 1'b0);
        rst = 1'b1;
        tick("rst_push77");
        rst = 1'b0;
        chk("rstmid.depth", 32'(bus.depth_count), 32'd0);
        chk("rstmid.top", bus.top_addr, 32'h0);
        chk("rstmid.overflow", 32'(bus.overflow), 32'd0);
        chk("rstmid.underflow", 32'(bus.underflow), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick("idle_after");
        chk("rstmid.no77", bus.top_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack that executes the call/return operations selected by the control decoder's Stack_Enable and Stack_Write lines.
- JAL pushes the link address supplied by the PC stage. RET pops the stack and presents the return target to the PC mux.
- Keeps one independent stack per execution context, chosen by Ctx_Sel, so CTX context switches do not corrupt another context's call chain.
- Sits between the control decoder / PC-increment logic and the next-PC mux.

Parameters:
- ADDR_W, 32, width of stored return addresses
- DEPTH, 16, entries per context stack; must be a power of two, at least 2
- NUM_CTX, 2, number of independent context stacks
- CTX_W, 1, width of Ctx_Sel; must satisfy 2^CTX_W >= NUM_CTX

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  pipeline advance; 0 freezes all state (halt/stall)
- Stack_Enable  in  1  stack operation requested, from the decoder
- Stack_Write  in  1  1 = push (JAL), 0 = pop (RET); valid only when Stack_Enable=1
- Push_Addr  in  ADDR_W  link address (PC+1) to push
- Ctx_Sel  in  CTX_W  active context index
- Top_Addr  out  ADDR_W  top entry of the selected context stack (combinational)
- Depth_Count  out  $clog2(DEPTH+1)  number of valid entries in the selected context
- Empty  out  1  selected context stack has 0 entries
- Full  out  1  selected context stack has DEPTH entries
- Overflow  out  1  sticky: a push was attempted while full, in any context
- Underflow  out  1  sticky: a pop was attempted while empty, in any context

Behaviour:
- **Reset** (Reset=1 at a rising edge): every context pointer = 0, all storage entries = 0, Overflow = 0, Underflow = 0. After reset: Top_Addr=0, Depth_Count=0, Empty=1, Full=0. Reset takes priority over Enable and over any stack operation.
- **Storage:** NUM_CTX x DEPTH x ADDR_W register array. Each context has its own pointer `ptr[c]` (0..DEPTH) giving the number of valid entries.
- **Read path:** combinational, zero latency.
  - Top_Addr = entry[Ctx_Sel][ptr-1] when ptr>0, else 0.
  - Depth_Count = ptr[Ctx_Sel]; Empty = (ptr==0); Full = (ptr==DEPTH).
  - RET uses Top_Addr in the same cycle that the pop is issued.
- **Operation decode** (evaluated only when Enable=1 and Reset=0):
  - Stack_Enable=0: no change.
  - Push (Stack_Enable=1, Stack_Write=1), not full: entry[Ctx_Sel][ptr] <= Push_Addr and ptr <= ptr+1 at the edge. The new value is visible on Top_Addr the following cycle.
  - Push while full: array and ptr unchanged; Overflow <= 1.
  - Pop (Stack_Enable=1, Stack_Write=0), not empty: ptr <= ptr-1. Entry contents are left in place (no clearing). Top_Addr shows the new top the following cycle.
  - Pop while empty: ptr stays 0; Underflow <= 1.
- **Enable=0:** no state changes at all, including the sticky flags. Outputs still track Ctx_Sel combinationally.
- **Context switching:** only the context selected by Ctx_Sel in the current cycle is modified; all other contexts hold. A Ctx_Sel change takes effect on the outputs immediately and needs no flush.
- **Sticky flags:** Overflow and Underflow are global (not per context) and clear only on Reset.
- **Boundaries:**
  - At ptr=DEPTH-1 a push succeeds and Full asserts the next cycle.
  - At ptr=1 a pop succeeds and Empty asserts the next cycle.
  - Pointer arithmetic is saturating, never modular; a push never wraps onto entry 0.
- **Reset mid-sequence:** a push or pop issued in the same cycle as Reset is discarded.
- **Structure:** the block has no FSM. State is the array, the per-context pointers and the two flags.

Test Plan:
- Reset, then Ctx_Sel=0, push 0x10, 0x20, 0x30 on consecutive enabled cycles -> Depth_Count=3, Top_Addr=0x30. Three pops -> Top_Addr reads 0x30, 0x20, 0x10 in the pop cycles; afterwards Empty=1, Top_Addr=0, Underflow=0.
- DEPTH=16: push 0x100..0x10F -> Full=1, Overflow=0. A 17th push of 0x200 -> Overflow=1, Top_Addr still 0x10F, Depth_Count=16.
- From reset, pop with an empty stack -> Underflow=1, Depth_Count=0. Then push 0x44 -> Top_Addr=0x44 and Underflow stays 1.
- Context isolation:
  - Ctx 0: push 0xA; switch to ctx 1, push 0xB and 0xC -> Top_Addr=0xC, Depth_Count=2.
  - Switch back to ctx 0 -> Top_Addr=0xA, Depth_Count=1 in the same cycle.
  - Pop ctx 0 -> ctx 1 still has Top_Addr=0xC.
- Enable=0 with Stack_Enable=1, Stack_Write=1, Push_Addr=0x55 held for 3 cycles -> no change. Pop with Enable=0 on an empty stack -> Underflow stays 0.
- With 2 entries pushed, assert Reset together with a push of 0x77 -> after the edge Depth_Count=0, Top_Addr=0, both flags 0, and 0x77 is never observable.
